alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Front-end controller for the full ALU: accepts one operation at a time over a valid/ready handshake and latches the operands.
- Single-cycle ops (ADD, SUB, AND, OR, SLL, SRA) are steered through the 6-input result mux by driving its 5-bit select.
- Multi-cycle ops (MULT, DIV) are launched on the multdiv unit with a start pulse, and the controller waits for its done.
- The result and exception flag are held on the output until the consumer accepts them.

Parameters:
- DATA_W, 32, operand/result width.
- TIMEOUT, 64, max cycles in WAIT_MD before an abort; must be ≥ 2.
- CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept (high only in IDLE).
- in_op  in  5  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRA, 6 MULT, 7 DIV; 8–31 illegal.
- in_a, in_b  in  DATA_W  operands.
- op_a, op_b  out  DATA_W  latched operands to the datapath.
- mux_sel  out  5  select to the 6-to-1 result mux.
- alu_result  in  DATA_W  output of the 6-to-1 mux.
- alu_ovf  in  1  ALU overflow for ADD/SUB.
- md_start  out  1  one-cycle start pulse to multdiv.
- md_is_div  out  1  0 = multiply, 1 = divide; stable from start until done.
- md_done  in  1  multdiv result ready.
- md_result  in  DATA_W  multdiv result.
- md_exc  in  1  multdiv exception (overflow / divide-by-zero).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_result  out  DATA_W  registered result.
- out_exc  out  1  registered exception.

Behaviour:
- States: IDLE, EXEC, WAIT_MD, HOLD (binary encoded).
- Reset values:
  - state IDLE.
  - in_ready = 1.
  - out_valid, out_exc, md_start, md_is_div = 0.
  - out_result, op_a, op_b = 0.
  - mux_sel = 0.
  - timeout counter = 0.
- Reset mid-operation: the next state is IDLE on that edge. Any pending multdiv result is discarded, and a later md_done is ignored.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_op, in_a, in_b; go to EXEC.
- EXEC (exactly one cycle):
  - mux_sel = latched op when op ≤ 5, else 0.
  - op 0–5: capture alu_result into out_result; out_exc = alu_ovf for ops 0/1, else 0. Go to HOLD.
  - op 6/7: md_start = 1 for this cycle only; md_is_div = op[0]; clear the counter. Go to WAIT_MD.
  - op ≥ 8: out_result = 0, out_exc = 1. Go to HOLD.
- WAIT_MD:
  - The counter increments each cycle.
  - md_done = 1: capture md_result and md_exc. Go to HOLD.
  - Otherwise, if counter == TIMEOUT−1: out_result = 0, out_exc = 1. Go to HOLD.
  - If md_done and the timeout coincide, md_done wins.
- HOLD:
  - out_valid = 1; out_result and out_exc are stable.
  - On out_ready: go to IDLE; out_valid falls on that edge.
  - in_ready stays 0 (no overlap of requests).
- md_done outside WAIT_MD is ignored.
- Latency:
  - Request accepted at edge T.
  - Single-cycle or illegal op: out_valid high from edge T+2.
  - Multi-cycle op: md_start high in cycle T+1. If md_done is sampled at edge D, out_valid is high from edge D+1.
- Throughput: one op per 3 cycles minimum, when out_ready is held high.
- op_a and op_b hold their values from acceptance until the next acceptance.
- No combinational path from any input to in_ready or out_valid.

Optional Feature:
- Macro: ALU_SEQ_PERF_EN.
- When defined, adds the following outputs:
  - perf_ops (out, 32): increments on each out_valid & out_ready.
  - perf_busy (out, 32): increments every cycle state ≠ IDLE.
  - perf_timeouts (out, 16): increments on each timeout abort; saturates at 0xFFFF.
- All counters reset to 0 on reset. perf_ops and perf_busy wrap.
- When undefined: these ports and their logic do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset then ADD (op 0), a=5, b=7, alu_result=12 driven by the bench, out_ready=1 → mux_sel=0 during EXEC; out_valid at T+2; out_result=12; out_exc=0; in_ready back to 1 the cycle after the handshake.
- SUB (op 1) with alu_result=0x8000_0000 and alu_ovf=1, out_ready held 0 for 5 cycles → out_valid stays 1 and out_result/out_exc stay stable; in_ready stays 0; releases when out_ready=1.
- DIV (op 7), a=100, b=7; model returns md_done with md_result=14 four cycles after start → md_start is a one-cycle pulse, md_is_div=1, out_result=14 one cycle after done.
- MULT (op 6) with md_done never asserted, TIMEOUT=64 → out_valid with out_result=0, out_exc=1 exactly 64 WAIT_MD cycles after EXEC; a late md_done is ignored. With ALU_SEQ_PERF_EN defined, perf_timeouts=1.
- Illegal op 12 → out_result=0, out_exc=1, out_valid at T+2, md_start never asserted.
- Reset asserted during WAIT_MD, then md_done pulsed → state IDLE, out_valid=0, in_ready=1, md_done produces no output; a following OR (op 3) completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: front-end controller for the full ALU.
// Accepts one operation at a time, steers single-cycle ops through the
// result mux, launches MULT/DIV on the multdiv unit with a bounded wait,
// and holds the result until the consumer takes it.
// Optional build macro: ALU_SEQ_PERF_EN adds performance counters.
module alu_op_sequencer #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [4:0]        mux_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_ovf,
    output logic              md_start,
    output logic              md_is_div,
    input  logic              md_done,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_exc
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [31:0]       perf_ops,
    output logic [31:0]       perf_busy,
    output logic [15:0]       perf_timeouts
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        WAIT_MD = 2'd2,
        HOLD    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [4:0]       op;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // Abort condition: last allowed WAIT_MD cycle with no result; md_done wins a tie.
    assign timeout_hit = (state == WAIT_MD) && !md_done && (cnt == CNT_LAST);

    // Control FSM; every output is a register so nothing reaches in_ready/out_valid combinationally.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out_exc    <= 1'b0;
            out_result <= '0;
            md_start   <= 1'b0;
            md_is_div  <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            op         <= 5'd0;
            mux_sel    <= 5'd0;
            cnt        <= '0;
        end else begin
            md_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op       <= in_op;
                        op_a     <= in_a;
                        op_b     <= in_b;
                        in_ready <= 1'b0;
                        // Select is set up now so it is valid for the whole EXEC cycle.
                        mux_sel  <= (in_op < 5'd6) ? in_op : 5'd0;
                        if (in_op == 5'd6 || in_op == 5'd7) begin
                            md_start  <= 1'b1;
                            md_is_div <= in_op[0];
                        end
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (op < 5'd6) begin
                        out_result <= alu_result;
                        out_exc    <= (op == 5'd0 || op == 5'd1) ? alu_ovf : 1'b0;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end else if (op < 5'd8) begin
                        cnt   <= '0;
                        state <= WAIT_MD;
                    end else begin
                        out_result <= '0;
                        out_exc    <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                WAIT_MD: begin
                    cnt <= cnt + CNT_ONE;
                    if (md_done) begin
                        out_result <= md_result;
                        out_exc    <= md_exc;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end else if (timeout_hit) begin
                        out_result <= '0;
                        out_exc    <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // Performance counters: completed ops, busy cycles, and saturating timeout aborts.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ops      <= 32'd0;
            perf_busy     <= 32'd0;
            perf_timeouts <= 16'd0;
        end else begin
            if (out_valid && out_ready) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (state != IDLE) begin
                perf_busy <= perf_busy + 32'd1;
            end
            if (timeout_hit && perf_timeouts != 16'hFFFF) begin
                perf_timeouts <= perf_timeouts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level reference model.
module tb_alu_op_sequencer;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 7;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [4:0]        in_op = 5'd0;
    logic [DATA_W-1:0] in_a = '0;
    logic [DATA_W-1:0] in_b = '0;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [4:0]        mux_sel;
    logic [DATA_W-1:0] alu_result = '0;
    logic              alu_ovf = 1'b0;
    logic              md_start;
    logic              md_is_div;
    logic              md_done = 1'b0;
    logic [DATA_W-1:0] md_result = '0;
    logic              md_exc = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_result;
    logic              out_exc;
`ifdef ALU_SEQ_PERF_EN
    logic [31:0]       perf_ops;
    logic [31:0]       perf_busy;
    logic [15:0]       perf_timeouts;
`endif

    alu_op_sequencer #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .op_a(op_a), .op_b(op_b),
        .mux_sel(mux_sel), .alu_result(alu_result), .alu_ovf(alu_ovf),
        .md_start(md_start), .md_is_div(md_is_div), .md_done(md_done),
        .md_result(md_result), .md_exc(md_exc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_exc(out_exc)
`ifdef ALU_SEQ_PERF_EN
        , .perf_ops(perf_ops), .perf_busy(perf_busy), .perf_timeouts(perf_timeouts)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit rnd_ready = 1'b0;

    // Reference model: one outstanding transaction, described by when it was
    // accepted and what result it ends with.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_acc = -10;
    logic [4:0]  m_op = 5'd0;
    logic [31:0] m_res = '0;
    logic        m_exc = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic        m_div = 1'b0;
    int unsigned m_ops = 0;
    int unsigned m_busycnt = 0;
    int unsigned m_to = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got 0x%0h want 0x%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clock) begin
        cyc = cyc + 1;
        if (reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_acc = -10;
            m_res = '0; m_exc = 1'b0; m_a = '0; m_b = '0; m_div = 1'b0;
            m_ops = 0; m_busycnt = 0; m_to = 0;
        end else begin
            if (m_busy) m_busycnt++;
            if (!m_busy) begin
                if (in_valid) begin
                    m_busy = 1'b1; m_done = 1'b0; m_acc = cyc;
                    m_op = in_op; m_a = in_a; m_b = in_b;
                    if (in_op == 5'd6 || in_op == 5'd7) m_div = in_op[0];
                end
            end else if (!m_done) begin
                if (cyc == m_acc + 1) begin
                    if (m_op < 5'd6) begin
                        m_res = alu_result;
                        m_exc = (m_op < 5'd2) ? alu_ovf : 1'b0;
                        m_done = 1'b1;
                    end else if (m_op >= 5'd8) begin
                        m_res = '0; m_exc = 1'b1; m_done = 1'b1;
                    end
                end else if (md_done) begin
                    m_res = md_result; m_exc = md_exc; m_done = 1'b1;
                end else if (cyc == m_acc + 1 + TIMEOUT) begin
                    m_res = '0; m_exc = 1'b1; m_done = 1'b1;
                    if (m_to < 32'hFFFF) m_to++;
                end
            end else if (out_ready) begin
                m_busy = 1'b0;
                m_ops++;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("in_ready", in_ready, !m_busy);
            chk("out_valid", out_valid, m_busy && m_done);
            chk("out_result", out_result, m_res);
            chk("out_exc", out_exc, m_exc);
            chk("op_a", op_a, m_a);
            chk("op_b", op_b, m_b);
            chk("md_start", md_start, m_busy && (m_op == 5'd6 || m_op == 5'd7) && cyc == m_acc);
            if (m_busy && cyc == m_acc)
                chk("mux_sel", mux_sel, (m_op < 5'd6) ? m_op : 5'd0);
            if (m_busy && !m_done && (m_op == 5'd6 || m_op == 5'd7))
                chk("md_is_div", md_is_div, m_div);
`ifdef ALU_SEQ_PERF_EN
            chk("perf_ops", perf_ops, m_ops);
            chk("perf_busy", perf_busy, m_busycnt);
            chk("perf_timeouts", perf_timeouts, m_to);
`endif
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        bit ok = 1'b0;
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        while (!ok && n < 300) begin
            step();
            n++;
            ok = m_busy && (m_acc == cyc);
        end
        in_valid = 1'b0;
        chk("accept_bound", {63'd0, ok}, 64'd1);
    endtask

    task automatic pulse_done(input int d, input logic [31:0] r, input logic e);
        for (int i = 0; i < d; i++) step();
        md_done = 1'b1; md_result = r; md_exc = e;
        step();
        md_done = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((m_busy || in_ready !== 1'b1) && n < 300) begin
            step();
            n++;
        end
        chk("drain_bound", {62'd0, m_busy, in_ready}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] rop;
        int d;
        int n;

        // Reset values
        step();
        chk_en = 1'b1;
        step();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_exc", out_exc, 0);
        chk("rst_md_start", md_start, 0);
        chk("rst_md_is_div", md_is_div, 0);
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_op_a", op_a, 0);

        // ADD 5+7 = 12
        out_ready = 1'b1; alu_result = 32'd12; alu_ovf = 1'b0;
        issue(5'd0, 32'd5, 32'd7);
        chk("add_mux_sel", mux_sel, 0);
        chk("add_in_ready_exec", in_ready, 0);
        chk("add_valid_exec", out_valid, 0);
        step();
        chk("add_valid_t2", out_valid, 1);
        chk("add_result", out_result, 12);
        chk("add_exc", out_exc, 0);
        chk("model_add_result", m_res, 12);
        step();
        chk("add_in_ready_back", in_ready, 1);
        chk("add_valid_fall", out_valid, 0);

        // SUB with overflow, consumer stalls 5 cycles
        out_ready = 1'b0; alu_result = 32'h8000_0000; alu_ovf = 1'b1;
        issue(5'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
        chk("sub_mux_sel", mux_sel, 1);
        step();
        alu_result = 32'd0; alu_ovf = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("sub_hold_valid", out_valid, 1);
            chk("sub_hold_result", out_result, 32'h8000_0000);
            chk("sub_hold_exc", out_exc, 1);
            chk("sub_hold_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("sub_release_valid", out_valid, 0);
        chk("sub_release_in_ready", in_ready, 1);

        // DIV 100/7 = 14, done four cycles after start
        issue(5'd7, 32'd100, 32'd7);
        chk("div_md_start", md_start, 1);
        chk("div_is_div", md_is_div, 1);
        chk("div_mux_sel", mux_sel, 0);
        step();
        chk("div_start_pulse", md_start, 0);
        step(); step(); step();
        md_done = 1'b1; md_result = 32'd14; md_exc = 1'b0;
        chk("div_valid_before", out_valid, 0);
        step();
        md_done = 1'b0;
        chk("div_valid", out_valid, 1);
        chk("div_result", out_result, 14);
        chk("model_div_result", m_res, 14);
        step();

        // MULT that never completes: timeout abort
        issue(5'd6, 32'd3, 32'd4);
        chk("mul_is_div", md_is_div, 0);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        chk("timeout_latency", n, TIMEOUT + 1);
        chk("timeout_result", out_result, 0);
        chk("timeout_exc", out_exc, 1);
`ifdef ALU_SEQ_PERF_EN
        chk("perf_timeouts_one", perf_timeouts, 1);
`endif
        step();
        md_done = 1'b1; md_result = 32'hDEAD; md_exc = 1'b0;
        step();
        md_done = 1'b0;
        chk("late_done_valid", out_valid, 0);
        chk("late_done_result", out_result, 0);
        step();
        chk("late_done_in_ready", in_ready, 1);

        // Illegal opcode 12
        issue(5'd12, 32'd1, 32'd2);
        chk("ill_md_start", md_start, 0);
        chk("ill_mux_sel", mux_sel, 0);
        step();
        chk("ill_valid", out_valid, 1);
        chk("ill_result", out_result, 0);
        chk("ill_exc", out_exc, 1);
        step();

        // Reset during WAIT_MD, then a stray md_done, then OR
        issue(5'd6, 32'd9, 32'd9);
        for (int i = 0; i < 10; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_md_is_div", md_is_div, 0);
        md_done = 1'b1; md_result = 32'h1234; md_exc = 1'b1;
        step();
        md_done = 1'b0;
        step();
        chk("stray_done_valid", out_valid, 0);
        chk("stray_done_result", out_result, 0);
        alu_result = 32'hF0F0_FFFF;
        issue(5'd3, 32'hF0F0_0F0F, 32'h0000_FFFF);
        chk("or_mux_sel", mux_sel, 3);
        step();
        chk("or_valid", out_valid, 1);
        chk("or_result", out_result, 32'hF0F0_FFFF);
        chk("or_exc", out_exc, 0);
        step();

        // Randomized traffic
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) rop = 5'($urandom_range(8, 31));
            else rop = 5'($urandom_range(0, 7));
            alu_result = $urandom;
            alu_ovf = 1'($urandom_range(0, 1));
            issue(rop, $urandom, $urandom);
            if (rop == 5'd6 || rop == 5'd7) begin
                if ($urandom_range(0, 9) == 0) d = $urandom_range(60, 70);
                else d = $urandom_range(0, 8);
                pulse_done(d, $urandom, 1'($urandom_range(0, 1)));
            end
            drain();
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
